// File: rtl/moore_seq_10110_pkg.sv
// rtl/moore_seq_10110_pkg.sv - state encoding, pattern constants and transition function for the 10110 detector
package moore_seq_10110_pkg;

   typedef enum logic [2:0] {
      S0     = 3'd0,
      S1     = 3'd1,
      S10    = 3'd2,
      S101   = 3'd3,
      S1011  = 3'd4,
      S10110 = 3'd5
   } state_e;

   localparam logic [4:0] PATTERN     = 5'b10110;
   localparam int         PATTERN_LEN = 5;

   // Advance on the expected pattern bit; otherwise fall back to the longest
   // pattern prefix that is still a suffix of the bits seen so far.
   function automatic state_e next_state(input state_e s, input logic b);
      state_e n;
      n = S0;
      case (s)
         S0:      n = (b == PATTERN[PATTERN_LEN-1]) ? S1     : S0;
         S1:      n = (b == PATTERN[PATTERN_LEN-2]) ? S10    : S1;
         S10:     n = (b == PATTERN[PATTERN_LEN-3]) ? S101   : S0;
         S101:    n = (b == PATTERN[PATTERN_LEN-4]) ? S1011  : S10;
         S1011:   n = (b == PATTERN[PATTERN_LEN-5]) ? S10110 : S1;
         S10110:  n = b ? S101 : S0;
         default: n = S0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/det_sat_counter.sv
// rtl/det_sat_counter.sv - saturating event counter for detector matches
module det_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/moore_seq_10110_ov.sv
// rtl/moore_seq_10110_ov.sv - overlapping 10110 Moore FSM with registered match flag
module moore_seq_10110_ov
   import moore_seq_10110_pkg::*;
(
   input  logic in_seq_i,
   input  logic clk_i,
   input  logic rst_ni,
   output logic det_o,
   output logic hit_o
);

   state_e state_q;
   state_e state_d;
   logic   det_q;

   assign state_d = next_state(state_q, in_seq_i);
   // Strobe for the counter: high in the cycle whose edge will raise det_o.
   assign hit_o   = (state_d == S10110);
   assign det_o   = det_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S0;
         det_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         det_q   <= (state_d == S10110);
      end
   end

endmodule

// File: rtl/moore_seq_10110_det.sv
// rtl/moore_seq_10110_det.sv - 10110 serial detector top; MOORE_SEQ_10110_CNT_EN adds the det_cnt match counter
module moore_seq_10110_det
   import moore_seq_10110_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             in_seq,
   input  logic             clk,
   input  logic             rst,
   output logic             det_out
`ifdef MOORE_SEQ_10110_CNT_EN
   ,
   output logic [CNT_W-1:0] det_cnt
`endif
);

   logic hit;

   if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
      $error("moore_seq_10110_det: CNT_W must be within 1..32");
   end

   moore_seq_10110_ov u_fsm (
      .in_seq_i (in_seq),
      .clk_i    (clk),
      .rst_ni   (rst),
      .det_o    (det_out),
      .hit_o    (hit)
   );

`ifdef MOORE_SEQ_10110_CNT_EN
   det_sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk_i  (clk),
      .rst_ni (rst),
      .inc_i  (hit),
      .cnt_o  (det_cnt)
   );
`else
   logic unused_hit;
   assign unused_hit = hit;
`endif

endmodule

// File: tb/tb_moore_seq_10110_det.sv
// tb/tb_moore_seq_10110_det.sv - scoreboard bench for the 10110 detector against a last-five-bits reference model
module tb_moore_seq_10110_det;

`ifdef MOORE_SEQ_10110_CNT_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 8;
`endif
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      logic det;
      int   cnt;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             in_seq;
   logic             det_out;
`ifdef MOORE_SEQ_10110_CNT_EN
   logic [CNT_W-1:0] det_cnt;
`endif

   int   passed;
   int   total;
   exp_t exp_q[$];
   logic hist[$];
   int   match_cnt;
   logic [4:0] ref_pat;

   moore_seq_10110_det #(
      .CNT_W (CNT_W)
   ) dut (
      .in_seq  (in_seq),
      .clk     (clk),
      .rst     (rst),
      .det_out (det_out)
`ifdef MOORE_SEQ_10110_CNT_EN
      ,
      .det_cnt (det_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic hist_matches();
      if (hist.size() != 5) return 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (hist[i] !== ref_pat[4-i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Reference: a match is simply "the last five bits since reset spell 10110".
   always @(posedge clk or negedge rst) begin
      exp_t e;
      if (!rst) begin
         hist.delete();
         match_cnt = 0;
         if (clk) begin
            e.det = 1'b0;
            e.cnt = 0;
            exp_q.push_back(e);
         end
      end else begin
         hist.push_back(in_seq);
         if (hist.size() > 5) void'(hist.pop_front());
         e.det = hist_matches();
         if (e.det && match_cnt < CNT_MAX) match_cnt++;
         e.cnt = match_cnt;
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("det_out", {31'd0, det_out}, {31'd0, e.det});
`ifdef MOORE_SEQ_10110_CNT_EN
         check("det_cnt", 32'(det_cnt), 32'(e.cnt));
`endif
      end
   end

   task automatic check_in_reset(input string name);
      check({name, "_det"}, {31'd0, det_out}, 32'd0);
`ifdef MOORE_SEQ_10110_CNT_EN
      check({name, "_cnt"}, 32'(det_cnt), 32'd0);
`endif
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      in_seq = b;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic hold_reset(input int n);
      @(negedge clk);
      #2 rst = 1'b0;
      in_seq = 1'bx;
      #1 check_in_reset("reset_async");
      repeat (n) @(negedge clk);
      #2 rst = 1'b1;
      in_seq = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check_in_reset("reset_pulse");
      in_seq = 1'b0;
      #1 rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      passed  = 0;
      total   = 0;
      ref_pat = 5'b10110;
      rst     = 1'b0;
      in_seq  = 1'bx;
      #1 check_in_reset("reset_init");
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      in_seq = 1'b0;

      send_bits(32'b1011010110, 10);
      send_bits(32'b0000, 4);
      send_bits(32'b10110110, 8);
      send_bits(32'b000, 3);
      send_bits(32'b101110, 6);
      send_bits(32'b100110, 6);
      send_bits(32'b10100, 5);
      send_bits(32'b000, 3);

      send_bits(32'b1011, 4);
      pulse_reset();
      send_bits(32'b000, 3);

      send_bits(32'b10110, 5);
      pulse_reset();
      send_bits(32'b00, 2);

      hold_reset(3);
      send_bits(32'b1011010110, 10);
      send_bits(32'b1011010110, 10);
      send_bits(32'b10110, 5);
      send_bits(32'b000, 3);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) send_bits(32'b10110, 5);
         else send_bit(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 299) == 0) pulse_reset();
      end

      repeat (3) @(negedge clk);
      #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
